// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   if_state_e   : fetch FSM states (four byte issues, finish, hold)
//   ZERO_WORD    : bubble value for PC / instruction outputs
//   issue_offset : byte offset within the word that a given ISSUE state reads
package if_fetch_pkg;

  typedef enum logic [2:0] {
    IF_ISSUE0 = 3'd0,
    IF_ISSUE1 = 3'd1,
    IF_ISSUE2 = 3'd2,
    IF_ISSUE3 = 3'd3,
    IF_FINISH = 3'd4,
    IF_HOLD   = 3'd5
  } if_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  function automatic logic [31:0] issue_offset(input if_state_e s);
    logic [31:0] off;
    off = 32'd0;
    case (s)
      IF_ISSUE1: off = 32'd1;
      IF_ISSUE2: off = 32'd2;
      IF_ISSUE3: off = 32'd3;
      default:   off = 32'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage. Owns the PC and assembles each 32-bit instruction
// from four byte reads on the shared byte-wide memory port (read data returns
// one cycle after the address). Delivers {pc, inst} to the IF/ID latch.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   rdy                 global ready; 0 freezes all state
//   stall[4:0]          pipeline stall vector; only bit 0 (IF) is used here
//   branch_flag/target  redirect from EX (target forced word-aligned)
//   mem_grant, mem_din  port grant for this cycle, byte for last cycle's address
//   mem_req, mem_addr   port request and byte address
//   if_pc, if_inst      delivered instruction (zero when if_valid=0)
//   if_valid            delivery strobe
//   stall_req           fetch in flight (ISSUE states)
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [4:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stall_req
);

  if_state_e   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  // b0..b2 while issuing; b3 is only written when the word parks in HOLD.
  logic [31:0] r_buf, w_buf_nxt;

  logic        w_issue;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_vld;
  logic [31:0] w_pc_out;
  logic [31:0] w_inst;
  logic        w_sreq;
  logic        w_unused;

  assign w_unused = ^{stall[4:1], branch_target[1:0]};

  assign w_issue = (r_state == IF_ISSUE0) || (r_state == IF_ISSUE1) ||
                   (r_state == IF_ISSUE2) || (r_state == IF_ISSUE3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IF_ISSUE0;
      r_pc    <= RESET_PC;
      r_buf   <= ZERO_WORD;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_req       = 1'b0;
    w_addr      = ZERO_WORD;
    w_vld       = 1'b0;
    w_pc_out    = ZERO_WORD;
    w_inst      = ZERO_WORD;
    w_sreq      = 1'b0;

    // Outputs are forced low while reset is asserted so downstream sees a
    // bubble immediately, not only after the next clock.
    if (rst) begin
      w_sreq = w_issue;
      if (rdy) begin
        // The port is driven on an ISSUE cycle even if a branch arrives; the
        // returned byte is simply never captured.
        if (w_issue && mem_grant) begin
          w_req  = 1'b1;
          w_addr = r_pc + issue_offset(r_state);
        end

        if (branch_flag) begin
          w_pc_nxt    = {branch_target[31:2], 2'b00};
          w_state_nxt = IF_ISSUE0;
        end else begin
          case (r_state)
            IF_ISSUE0, IF_ISSUE1, IF_ISSUE2, IF_ISSUE3: begin
              if (!mem_grant) begin
                // Lost the port: restart the whole word, stale bytes get
                // overwritten on the retry.
                w_state_nxt = IF_ISSUE0;
              end else begin
                case (r_state)
                  IF_ISSUE0: w_state_nxt = IF_ISSUE1;
                  IF_ISSUE1: begin
                    w_buf_nxt[7:0] = mem_din;
                    w_state_nxt    = IF_ISSUE2;
                  end
                  IF_ISSUE2: begin
                    w_buf_nxt[15:8] = mem_din;
                    w_state_nxt     = IF_ISSUE3;
                  end
                  default: begin
                    w_buf_nxt[23:16] = mem_din;
                    w_state_nxt      = IF_FINISH;
                  end
                endcase
              end
            end
            IF_FINISH: begin
              if (stall[0]) begin
                w_buf_nxt[31:24] = mem_din;
                w_state_nxt      = IF_HOLD;
              end else begin
                w_vld       = 1'b1;
                w_pc_out    = r_pc;
                w_inst      = {mem_din, r_buf[23:0]};
                w_pc_nxt    = r_pc + 32'd4;
                w_state_nxt = IF_ISSUE0;
              end
            end
            IF_HOLD: begin
              if (!stall[0]) begin
                w_vld       = 1'b1;
                w_pc_out    = r_pc;
                w_inst      = r_buf;
                w_pc_nxt    = r_pc + 32'd4;
                w_state_nxt = IF_ISSUE0;
              end
            end
            default: w_state_nxt = IF_ISSUE0;
          endcase
        end
      end
    end
  end

  assign mem_req   = w_req;
  assign mem_addr  = w_addr;
  assign if_valid  = w_vld;
  assign if_pc     = w_pc_out;
  assign if_inst   = w_inst;
  assign stall_req = w_sreq;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [4:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_grant;
  logic [7:0]  mem_din = 8'h00;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy;
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        sreq;
  } vec_t;

  vec_t tbl[$];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .mem_grant(mem_grant), .mem_din(mem_din),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Memory image: bytes 0..3 hold 13,00,00,00; elsewhere addr[7:0]^A5.
  function automatic logic [7:0] mem_at(input logic [31:0] a);
    logic [7:0] d;
    if (a == 32'd0)     d = 8'h13;
    else if (a < 32'd4) d = 8'h00;
    else                d = a[7:0] ^ 8'hA5;
    return d;
  endfunction

  // Byte port with one-cycle latency; data holds when nothing is requested.
  always @(posedge clk)
    if (mem_req) mem_din <= mem_at(mem_addr);

  task automatic row(input logic r, input logic st, input logic br, input logic [31:0] tgt,
                     input logic g, input logic req, input logic [31:0] addr, input logic vld,
                     input logic [31:0] pc, input logic [31:0] inst, input logic sreq);
    vec_t v;
    v.rdy = r; v.st = st; v.br = br; v.tgt = tgt; v.gnt = g;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.inst = inst; v.sreq = sreq;
    tbl.push_back(v);
  endtask

  task automatic iss(input logic [31:0] a);
    row(1, 0, 0, 0, 1, 1, a, 0, 0, 0, 1);
  endtask

  task automatic fin(input logic [31:0] p, input logic [31:0] i);
    row(1, 0, 0, 0, 1, 0, 0, 1, p, i, 0);
  endtask

  task automatic expect_out(input string nm, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc, input logic [31:0] inst,
                            input logic sreq);
    checks++;
    if (mem_req !== req || mem_addr !== addr || if_valid !== vld ||
        if_pc !== pc || if_inst !== inst || stall_req !== sreq) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h vld=%0b pc=%h inst=%h sreq=%0b, want req=%0b addr=%h vld=%0b pc=%h inst=%h sreq=%0b",
               nm, mem_req, mem_addr, if_valid, if_pc, if_inst, stall_req,
               req, addr, vld, pc, inst, sreq);
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; stall = 5'b0; branch_flag = 1'b0;
    branch_target = 32'h0; mem_grant = 1'b1;

    // Normal fetch from reset.
    iss(32'h0); iss(32'h1); iss(32'h2); iss(32'h3); fin(32'h0, 32'h0000_0013);
    iss(32'h4); iss(32'h5); iss(32'h6); iss(32'h7); fin(32'h4, 32'hA2A3_A0A1);
    // Branch in ISSUE2 to an unaligned target.
    iss(32'h8); iss(32'h9); row(1, 0, 1, 32'h0000_1006, 1, 1, 32'hA, 0, 0, 0, 1);
    iss(32'h1004); iss(32'h1005); iss(32'h1006); iss(32'h1007); fin(32'h1004, 32'hA2A3_A0A1);
    // stall[0] for 3 cycles from FINISH.
    iss(32'h1008); iss(32'h1009); iss(32'h100A); iss(32'h100B);
    row(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    fin(32'h1008, 32'hAEAF_ACAD);
    // Grant lost in ISSUE3 for 2 cycles.
    iss(32'h100C); iss(32'h100D); iss(32'h100E);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    iss(32'h100C); iss(32'h100D); iss(32'h100E); iss(32'h100F); fin(32'h100C, 32'hAAAB_A8A9);
    // rdy low for 4 cycles in ISSUE1.
    iss(32'h1010);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    iss(32'h1011); iss(32'h1012); iss(32'h1013); fin(32'h1010, 32'hB6B7_B4B5);
    // Branch near top of address space; byte addresses and pc+4 wrap.
    row(1, 0, 1, 32'hFFFF_FFFE, 1, 1, 32'h1014, 0, 0, 0, 1);
    iss(32'hFFFF_FFFC); iss(32'hFFFF_FFFD); iss(32'hFFFF_FFFE); iss(32'hFFFF_FFFF);
    fin(32'hFFFF_FFFC, 32'h5A5B_5859);
    // Branch in FINISH drops the word.
    iss(32'h0); iss(32'h1); iss(32'h2); iss(32'h3);
    row(1, 0, 1, 32'h0000_0020, 1, 0, 0, 0, 0, 0, 0);
    // Branch in HOLD drops the held word.
    iss(32'h20); iss(32'h21); iss(32'h22); iss(32'h23);
    row(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 32'h0000_0040, 1, 0, 0, 0, 0, 0, 0);
    iss(32'h40); iss(32'h41); iss(32'h42); iss(32'h43); fin(32'h40, 32'hE6E7_E4E5);

    // Reset state: every output held low even with rdy/grant high.
    @(negedge clk); @(negedge clk);
    #1 expect_out("reset", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      rdy = tbl[i].rdy;
      stall = {4'(i), tbl[i].st};
      branch_flag = tbl[i].br;
      branch_target = tbl[i].tgt;
      mem_grant = tbl[i].gnt;
      #1 expect_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld,
                    tbl[i].pc, tbl[i].inst, tbl[i].sreq);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of ISSUE2.
    rdy = 1'b1; stall = 5'b0; branch_flag = 1'b0; branch_target = 32'h0; mem_grant = 1'b1;
    #1 expect_out("arst_i0", 1, 32'h44, 0, 0, 0, 1);
    @(negedge clk);
    #1 expect_out("arst_i1", 1, 32'h45, 0, 0, 0, 1);
    @(negedge clk);
    #1 expect_out("arst_i2", 1, 32'h46, 0, 0, 0, 1);
    #2 rst = 1'b0;
    #1 expect_out("arst_now", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 expect_out("arst_rel0", 1, 32'h0, 0, 0, 0, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1 expect_out($sformatf("arst_rel%0d", k), 1, 32'(k), 0, 0, 0, 1);
    end
    @(negedge clk);
    #1 expect_out("arst_word", 0, 0, 1, 32'h0, 32'h0000_0013, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
